rx_frame_writer: RTL and testbench

- Parametrised successor of the receiver-to-memory control path.
- Takes words strobed by `Ack` from the serial receiver and writes them into a single-port frame memory at an auto-incrementing address.
- `Ready` marks end of frame. At frame end the block reports the word count and pulses a done flag.
- Adds configurable data width and depth, wrap or stop behaviour at a full buffer, and sticky overflow and drop error flags.

---
 rtl/rx_frame_writer.sv | 134 +++++++++++++
 tb/tb_rx_frame_writer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_writer.sv
// Receiver-to-frame-memory writer: auto-incrementing address, word count,
// wrap/stop at full buffer, sticky overflow and drop flags.
module rx_frame_writer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] rcvDataOut,
  input  logic              Ack,
  input  logic              Ready,
  input  logic              ClearFlags,
  output logic [DATA_W-1:0] memDataIn,
  output logic [ADDR_W-1:0] Address,
  output logic              WriteEnable,
  output logic [ADDR_W:0]   WordCount,
  output logic              FrameDone,
  output logic              Overflow,
  output logic              DropErr,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } state_t;

  localparam bit WRAP = (WRAP_MODE != 0);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic last;
  logic at_end;
  logic ovf_set, drop_set;

  assign at_end = (ptr == PTR_MAX);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (Ack) state_nxt = WRITE;
      WRITE: begin
        if (!last && at_end && !WRAP) state_nxt = FULL;
        else state_nxt = IDLE;
      end
      FULL:  if (Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ovf_set  = 1'b0;
    drop_set = 1'b0;
    unique case (1'b1)
      (state == WRITE): begin
        drop_set = Ack;
        ovf_set  = !last && at_end && WRAP;
      end
      (state == FULL): ovf_set = Ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr         <= '0;
      last        <= 1'b0;
      memDataIn   <= '0;
      Address     <= '0;
      WriteEnable <= 1'b0;
      WordCount   <= '0;
      FrameDone   <= 1'b0;
      Overflow    <= 1'b0;
      DropErr     <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      FrameDone   <= 1'b0;
      if (ovf_set) Overflow <= 1'b1;
      else if (ClearFlags) Overflow <= 1'b0;
      if (drop_set) DropErr <= 1'b1;
      else if (ClearFlags) DropErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Ack) begin
            memDataIn   <= rcvDataOut;
            Address     <= ptr;
            WriteEnable <= 1'b1;
            last        <= Ready;
          end else if (Ready && ptr != '0) begin
            WordCount <= {1'b0, ptr};
            FrameDone <= 1'b1;
            ptr       <= '0;
          end
        end
        WRITE: begin
          if (last) begin
            WordCount <= {1'b0, ptr} + (ADDR_W + 1)'(1);
            FrameDone <= 1'b1;
            ptr       <= '0;
          end else if (at_end) begin
            // stop mode holds ptr at the last slot while FULL
            ptr <= WRAP ? '0 : ptr;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        FULL: begin
          if (Ready) begin
            WordCount <= CNT_FULL;
            FrameDone <= 1'b1;
            ptr       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_writer.sv
// Scoreboard bench: wrap (DEPTH 16) and stop (DEPTH 4) writers
// driven by shared stimulus against a frame-level reference model.
module tb_rx_frame_writer;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int cyc;
    int wc;
  } fr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset = 1'b1;
  logic        Ack = 1'b0;
  logic        Ready = 1'b0;
  logic        ClearFlags = 1'b0;
  logic [15:0] rcvDataOut = '0;

  logic [15:0] mem_w, mem_s;
  logic [3:0]  addr_w;
  logic [1:0]  addr_s;
  logic [4:0]  wc_w;
  logic [2:0]  wc_s;
  logic        we_w, fd_w, ov_w, de_w, busy_w;
  logic        we_s, fd_s, ov_s, de_s, busy_s;

  rx_frame_writer #(
    .DATA_W(16), .ADDR_W(4), .DEPTH(16), .WRAP_MODE(1)
  ) u_wrap (
    .clk(clk), .Reset(Reset), .rcvDataOut(rcvDataOut),
    .Ack(Ack), .Ready(Ready), .ClearFlags(ClearFlags),
    .memDataIn(mem_w), .Address(addr_w),
    .WriteEnable(we_w), .WordCount(wc_w),
    .FrameDone(fd_w), .Overflow(ov_w),
    .DropErr(de_w), .Busy(busy_w)
  );

  rx_frame_writer #(
    .DATA_W(16), .ADDR_W(2), .DEPTH(4), .WRAP_MODE(0)
  ) u_stop (
    .clk(clk), .Reset(Reset), .rcvDataOut(rcvDataOut),
    .Ack(Ack), .Ready(Ready), .ClearFlags(ClearFlags),
    .memDataIn(mem_s), .Address(addr_s),
    .WriteEnable(we_s), .WordCount(wc_s),
    .FrameDone(fd_s), .Overflow(ov_s),
    .DropErr(de_s), .Busy(busy_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  wr_t wq0[$], wq1[$];
  fr_t fq0[$], fq1[$];
  wr_t ew0, ew1;
  fr_t ef0, ef1;

  // model: words accepted in current frame, pending WRITE cycle, flags
  int D[2] = '{16, 4};
  bit WM[2] = '{1'b1, 1'b0};
  int n[2];
  bit wrp[2];
  bit ovf[2];
  bit drp[2];
  int lwc[2];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic bit full(int i);
    return !WM[i] && n[i] == D[i];
  endfunction

  task automatic push_wr(int i, int c, int a, int d);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d & 16'hffff;
    if (i == 0) wq0.push_back(e);
    else wq1.push_back(e);
  endtask

  task automatic push_fr(int i, int c, int wc);
    fr_t e;
    e.cyc = c; e.wc = wc;
    lwc[i] = wc;
    if (i == 0) fq0.push_back(e);
    else fq1.push_back(e);
  endtask

  task automatic model(int i, bit a, bit r, bit c, int d);
    bit so, sd;
    so = 1'b0;
    sd = 1'b0;
    if (wrp[i]) begin
      wrp[i] = 1'b0;
      sd = a;
    end else if (full(i)) begin
      so = a;
      if (r) begin
        push_fr(i, cyc + 1, D[i]);
        n[i] = 0;
      end
    end else if (a) begin
      push_wr(i, cyc + 1, n[i] % D[i], d);
      n[i]++;
      wrp[i] = 1'b1;
      if (r) begin
        push_fr(i, cyc + 2, ((n[i] - 1) % D[i]) + 1);
        n[i] = 0;
      end else if (WM[i] && n[i] % D[i] == 0) begin
        so = 1'b1;
      end
    end else if (r) begin
      if (WM[i]) begin
        if (n[i] % D[i] != 0) push_fr(i, cyc + 1, n[i] % D[i]);
      end else if (n[i] > 0) begin
        push_fr(i, cyc + 1, n[i]);
      end
      n[i] = 0;
    end
    if (so) ovf[i] = 1'b1;
    else if (c) ovf[i] = 1'b0;
    if (sd) drp[i] = 1'b1;
    else if (c) drp[i] = 1'b0;
  endtask

  task automatic step(bit a, bit r, bit c, int d);
    @(negedge clk);
    Reset = 1'b0;
    Ack = a;
    Ready = r;
    ClearFlags = c;
    rcvDataOut = d[15:0];
    model(0, a, r, c, d);
    model(1, a, r, c, d);
  endtask

  task automatic idle(int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic settle();
    idle(2);
    chk("ovf wrap", int'(ov_w), int'(ovf[0]));
    chk("drop wrap", int'(de_w), int'(drp[0]));
    chk("busy wrap", int'(busy_w), int'(full(0)));
    chk("wcount wrap", int'(wc_w), lwc[0]);
    chk("ovf stop", int'(ov_s), int'(ovf[1]));
    chk("drop stop", int'(de_s), int'(drp[1]));
    chk("busy stop", int'(busy_s), int'(full(1)));
    chk("wcount stop", int'(wc_s), lwc[1]);
  endtask

  task automatic do_reset();
    int m;
    @(negedge clk);
    Reset = 1'b1;
    Ack = 1'b0;
    Ready = 1'b0;
    ClearFlags = 1'b0;
    // drop expectations that the reset abandons
    m = wq0.size();
    for (int j = 0; j < m; j++) begin
      ew0 = wq0.pop_front();
      if (ew0.cyc <= cyc) wq0.push_back(ew0);
    end
    m = wq1.size();
    for (int j = 0; j < m; j++) begin
      ew1 = wq1.pop_front();
      if (ew1.cyc <= cyc) wq1.push_back(ew1);
    end
    m = fq0.size();
    for (int j = 0; j < m; j++) begin
      ef0 = fq0.pop_front();
      if (ef0.cyc <= cyc) fq0.push_back(ef0);
    end
    m = fq1.size();
    for (int j = 0; j < m; j++) begin
      ef1 = fq1.pop_front();
      if (ef1.cyc <= cyc) fq1.push_back(ef1);
    end
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; wrp[i] = 0; ovf[i] = 0; drp[i] = 0; lwc[i] = 0;
    end
  endtask

  task automatic check_zero();
    idle(1);
    chk("reset outputs wrap",
        int'({mem_w, addr_w, we_w, wc_w, fd_w, ov_w, de_w, busy_w}), 0);
    chk("reset outputs stop",
        int'({mem_s, addr_s, we_s, wc_s, fd_s, ov_s, de_s, busy_s}), 0);
  endtask

  always @(negedge clk) begin
    if (we_w) begin
      if (wq0.size() == 0) chk("unexpected write wrap", 1, 0);
      else begin
        ew0 = wq0.pop_front();
        chk("write cycle wrap", cyc, ew0.cyc);
        chk("write addr wrap", int'(addr_w), ew0.addr);
        chk("write data wrap", int'(mem_w), ew0.data);
      end
    end
    if (fd_w) begin
      if (fq0.size() == 0) chk("unexpected done wrap", 1, 0);
      else begin
        ef0 = fq0.pop_front();
        chk("done cycle wrap", cyc, ef0.cyc);
        chk("done count wrap", int'(wc_w), ef0.wc);
      end
    end
  end

  always @(negedge clk) begin
    if (we_s) begin
      if (wq1.size() == 0) chk("unexpected write stop", 1, 0);
      else begin
        ew1 = wq1.pop_front();
        chk("write cycle stop", cyc, ew1.cyc);
        chk("write addr stop", int'(addr_s), ew1.addr);
        chk("write data stop", int'(mem_s), ew1.data);
      end
    end
    if (fd_s) begin
      if (fq1.size() == 0) chk("unexpected done stop", 1, 0);
      else begin
        ef1 = fq1.pop_front();
        chk("done cycle stop", cyc, ef1.cyc);
        chk("done count stop", int'(wc_s), ef1.wc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit b2b;
    int g;
    do_reset();
    check_zero();
    settle();

    // basic frame, then next frame restarts at address 0
    step(1, 0, 0, 16'hA001); idle(3);
    step(1, 0, 0, 16'hA002); idle(3);
    step(1, 1, 0, 16'hA003);
    settle();
    step(1, 0, 0, 16'hB000);
    settle();
    step(0, 1, 0, 0);
    settle();

    // 18 words without Ready, then Ready alone
    for (int k = 0; k < 18; k++) begin
      step(1, 0, 0, 16'h5000 + k);
      idle(1);
    end
    settle();
    step(0, 1, 0, 0);
    settle();
    step(0, 0, 1, 0);
    settle();

    // back-to-back Ack drops the second word
    step(1, 0, 0, 16'h1111);
    step(1, 0, 0, 16'h2222);
    settle();
    step(0, 0, 1, 0);
    settle();
    step(0, 1, 0, 0);
    settle();

    // reset during the WRITE cycle of the sixth word
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 16'h6000 + k);
      idle(1);
    end
    step(1, 0, 0, 16'h6005);
    do_reset();
    check_zero();
    settle();
    step(1, 0, 0, 16'hC0DE);
    settle();

    // close frame, then Ready alone with empty buffer
    step(1, 1, 0, 16'hC0DF);
    settle();
    step(0, 1, 0, 0);
    settle();

    b2b = 1'b0;
    for (int it = 0; it < 300; it++) begin
      step(1, !b2b && $urandom_range(0, 5) == 0, 0, int'($urandom));
      g = $urandom_range(0, 6);
      b2b = (g == 0);
      if (g != 0) begin
        idle(1);
        for (int j = 1; j < g; j++)
          step(0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, 0);
        if (it % 10 == 9) settle();
      end
    end
    settle();
    step(0, 1, 0, 0);
    settle();

    chk("writes drained wrap", wq0.size(), 0);
    chk("writes drained stop", wq1.size(), 0);
    chk("frames drained wrap", fq0.size(), 0);
    chk("frames drained stop", fq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
